// File: rtl/time_pkg.sv
// Shared types, digit limits and load-legality check for the HH:MM:SS BCD time register.
package time_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_T_MAX       = 4'd5;
  localparam bcd_digit_t MIN_T_MAX       = 4'd5;
  localparam bcd_digit_t ONES_MAX        = 4'd9;
  localparam bcd_digit_t HOUR_T_MAX      = 4'd2;
  localparam bcd_digit_t HOUR_O_MAX_AT_2 = 4'd3;

  // True when the six digits form a valid 24-hour time 00:00:00 .. 23:59:59.
  function automatic logic bcd_time_legal(input bcd_digit_t ht, input bcd_digit_t ho,
                                          input bcd_digit_t mt, input bcd_digit_t mo,
                                          input bcd_digit_t st, input bcd_digit_t so);
    logic ok;
    ok = (ht <= HOUR_T_MAX) && (ho <= ONES_MAX) &&
         (mt <= MIN_T_MAX)  && (mo <= ONES_MAX) &&
         (st <= SEC_T_MAX)  && (so <= ONES_MAX);
    if ((ht == HOUR_T_MAX) && (ho > HOUR_O_MAX_AT_2)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: wraps from max_val to 0, carry flags the wrapping increment.
module bcd_digit_counter
  import time_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  bcd_digit_t max_val,
  input  logic       inc,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t q,
  output logic       carry
);

  assign carry = inc && (q == max_val);

  // Load takes priority over increment; increment wraps at max_val.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= (q == max_val) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS 24-hour BCD time register: prescaled seconds time-base, digit cascade,
// validated time-set loads and registered status pulses.
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       hold,
  input  logic       set_valid,
  input  logic [3:0] set_ht,
  input  logic [3:0] set_ho,
  input  logic [3:0] set_mt,
  input  logic [3:0] set_mo,
  input  logic [3:0] set_st,
  input  logic [3:0] set_so,
  output logic [3:0] ht,
  output logic [3:0] ho,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       set_err
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          pre_step;
  logic          pre_wrap;
  logic          load_legal;
  logic          load_ok;
  logic          advance;
  bcd_digit_t    ho_max;
  logic          c_so, c_st, c_mo, c_mt, c_ho, c_ht;

  assign pre_step   = tick_en && !hold;
  assign pre_wrap   = pre_step && (pre == PRE_LAST);
  assign load_legal = bcd_time_legal(set_ht, set_ho, set_mt, set_mo, set_st, set_so);
  assign load_ok    = set_valid && load_legal;
  // A legal load discards a coincident advance.
  assign advance    = pre_wrap && !load_ok;

  // Hours ones stop at 3 in the twenties so that 23 rolls straight to 00.
  assign ho_max = (ht == HOUR_T_MAX) ? HOUR_O_MAX_AT_2 : ONES_MAX;

  // Prescaler: counts unheld ticks, wraps on the advancing tick, cleared by a legal load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (load_ok) begin
      pre <= '0;
    end else if (pre_step) begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
    end
  end

  // Status pulses, one clk wide, registered like the digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_pulse <= advance;
      day_pulse <= c_ht;
      set_err   <= set_valid && !load_legal;
    end
  end

  bcd_digit_counter u_so (.clk(clk), .rst(rst), .max_val(ONES_MAX),   .inc(advance),
                          .load(load_ok), .load_val(set_so), .q(so), .carry(c_so));
  bcd_digit_counter u_st (.clk(clk), .rst(rst), .max_val(SEC_T_MAX),  .inc(c_so),
                          .load(load_ok), .load_val(set_st), .q(st), .carry(c_st));
  bcd_digit_counter u_mo (.clk(clk), .rst(rst), .max_val(ONES_MAX),   .inc(c_st),
                          .load(load_ok), .load_val(set_mo), .q(mo), .carry(c_mo));
  bcd_digit_counter u_mt (.clk(clk), .rst(rst), .max_val(MIN_T_MAX),  .inc(c_mo),
                          .load(load_ok), .load_val(set_mt), .q(mt), .carry(c_mt));
  bcd_digit_counter u_ho (.clk(clk), .rst(rst), .max_val(ho_max),     .inc(c_mt),
                          .load(load_ok), .load_val(set_ho), .q(ho), .carry(c_ho));
  bcd_digit_counter u_ht (.clk(clk), .rst(rst), .max_val(HOUR_T_MAX), .inc(c_ho),
                          .load(load_ok), .load_val(set_ht), .q(ht), .carry(c_ht));

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench: two instances (TICK_DIV=1 and 4) against a seconds-of-day model.
module tb_bcd_time_counter;
  import time_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_en = 1'b0;
  logic        hold = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] sd = '0;

  logic [3:0] ht1, ho1, mt1, mo1, st1, so1;
  logic [3:0] ht4, ho4, mt4, mo4, st4, so4;
  logic       sec1, day1, err1, sec4, day4, err4;

  always #5 clk = ~clk;

  bcd_time_counter #(.TICK_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .hold(hold), .set_valid(set_valid),
    .set_ht(sd[23:20]), .set_ho(sd[19:16]), .set_mt(sd[15:12]),
    .set_mo(sd[11:8]), .set_st(sd[7:4]), .set_so(sd[3:0]),
    .ht(ht1), .ho(ho1), .mt(mt1), .mo(mo1), .st(st1), .so(so1),
    .sec_pulse(sec1), .day_pulse(day1), .set_err(err1));

  bcd_time_counter #(.TICK_DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .hold(hold), .set_valid(set_valid),
    .set_ht(sd[23:20]), .set_ho(sd[19:16]), .set_mt(sd[15:12]),
    .set_mo(sd[11:8]), .set_st(sd[7:4]), .set_so(sd[3:0]),
    .ht(ht4), .ho(ho4), .mt(mt4), .mo(mo4), .st(st4), .so(so4),
    .sec_pulse(sec4), .day_pulse(day4), .set_err(err4));

  wire [26:0] o1 = {ht1, ho1, mt1, mo1, st1, so1, sec1, day1, err1};
  wire [26:0] o4 = {ht4, ho4, mt4, mo4, st4, so4, sec4, day4, err4};

  int n_cmp = 0;
  int n_fail = 0;

  // Model: time as seconds of day, prescaler as a plain count.
  int mtime [2];
  int mpre  [2];
  bit ms    [2];
  bit md    [2];
  bit me    [2];
  int dv    [2] = '{1, 4};

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int from_bcd(input logic [23:0] d);
    int h, m, s;
    h = int'(d[23:20]) * 10 + int'(d[19:16]);
    m = int'(d[15:12]) * 10 + int'(d[11:8]);
    s = int'(d[7:4]) * 10 + int'(d[3:0]);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic bit bench_legal(input logic [23:0] d);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) if (int'(d[i*4 +: 4]) > 9) ok = 1'b0;
    if (int'(d[23:20]) * 10 + int'(d[19:16]) > 23) ok = 1'b0;
    if (int'(d[15:12]) > 5) ok = 1'b0;
    if (int'(d[7:4]) > 5) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [26:0] exp_vec(input int k);
    return {to_bcd(mtime[k]), ms[k], md[k], me[k]};
  endfunction

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mtime[k] = 0; mpre[k] = 0; ms[k] = 0; md[k] = 0; me[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; md[k] = 0; me[k] = 0;
      if (set_valid && bench_legal(sd)) begin
        mtime[k] = from_bcd(sd);
        mpre[k]  = 0;
      end else begin
        me[k] = set_valid;
        if (tick_en && !hold) begin
          if (mpre[k] == dv[k] - 1) begin
            mpre[k]  = 0;
            ms[k]    = 1;
            md[k]    = (mtime[k] == 86399);
            mtime[k] = (mtime[k] + 1) % 86400;
          end else begin
            mpre[k]++;
          end
        end
      end
    end
  endtask

  // Called at a negedge: drive inputs, advance model across the posedge, compare.
  task automatic step(input logic t, input logic h, input logic v, input logic [23:0] d);
    tick_en = t; hold = h; set_valid = v; sd = d;
    model_edge();
    @(negedge clk);
    check("model_div1", o1, exp_vec(0));
    check("model_div4", o4, exp_vec(1));
  endtask

  logic [23:0] loads [7] = '{24'h235950, 24'h095955, 24'h195957, 24'h245959,
                             24'h0a0000, 24'h125960, 24'h035959};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state_div1", o1, 27'd0);
    check("reset_state_div4", o4, 27'd0);

    check("legal_fn_235959", {26'd0, bcd_time_legal(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9)}, 27'd1);
    check("legal_fn_240000", {26'd0, bcd_time_legal(4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0)}, 27'd0);
    check("legal_fn_1A0000", {26'd0, bcd_time_legal(4'd1, 4'hA, 4'd0, 4'd0, 4'd0, 4'd0)}, 27'd0);
    check("legal_fn_126000", {26'd0, bcd_time_legal(4'd1, 4'd2, 4'd6, 4'd0, 4'd0, 4'd0)}, 27'd0);
    check("legal_fn_120060", {26'd0, bcd_time_legal(4'd1, 4'd2, 4'd0, 4'd0, 4'd6, 4'd0)}, 27'd0);

    // Reset mid-count at 12:34:56 with a load and tick pending.
    step(0, 0, 1, 24'h123456);
    check("load_123456", o1, {24'h123456, 3'b000});
    tick_en = 1'b1; set_valid = 1'b1; sd = 24'h111111;
    #3 rst = 1'b1;
    #1;
    check("async_reset_div1", o1, 27'd0);
    check("async_reset_div4", o4, 27'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Day rollover.
    step(0, 0, 1, 24'h235958);
    check("load_235958", o1, {24'h235958, 3'b000});
    step(1, 0, 0, 24'h0);
    check("adv_235959", o1, {24'h235959, 3'b100});
    step(1, 0, 0, 24'h0);
    check("day_wrap", o1, {24'h000000, 3'b110});

    // Hour carries.
    step(0, 0, 1, 24'h095959);
    step(1, 0, 0, 24'h0);
    check("carry_to_10", o1, {24'h100000, 3'b100});
    step(0, 0, 1, 24'h195959);
    step(1, 0, 0, 24'h0);
    check("carry_to_20", o1, {24'h200000, 3'b100});

    // Illegal loads: rejected, coincident tick still counts.
    step(1, 0, 1, 24'h240000);
    check("illegal_24", o1, {24'h200001, 3'b101});
    step(0, 0, 1, 24'h126000);
    check("illegal_60min", o1, {24'h200001, 3'b001});
    step(1, 0, 1, 24'h1a0000);
    check("illegal_1A", o1, {24'h200002, 3'b101});
    step(0, 0, 0, 24'h0);
    check("err_one_clk", o1, {24'h200002, 3'b000});

    // Legal load beats a coincident advance.
    step(0, 0, 1, 24'h045959);
    step(1, 0, 1, 24'h050000);
    check("load_beats_tick", o1, {24'h050000, 3'b000});

    // Hold freezes the TICK_DIV=4 prescaler.
    step(0, 0, 1, 24'h000000);
    step(1, 0, 0, 24'h0);
    step(1, 0, 0, 24'h0);
    repeat (3) step(1, 1, 0, 24'h0);
    check("hold_frozen_div1", o1, {24'h000002, 3'b000});
    check("hold_frozen_div4", o4, {24'h000000, 3'b000});
    step(1, 0, 0, 24'h0);
    check("resume_pre3_div4", o4, {24'h000000, 3'b000});
    step(1, 0, 0, 24'h0);
    check("resume_adv_div4", o4, {24'h000001, 3'b100});
    step(0, 1, 1, 24'h010203);
    check("load_under_hold", o1, {24'h010203, 3'b000});

    // Mixed traffic around carries and wraps, checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      logic v;
      v = ($urandom_range(0, 19) == 0);
      step(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0), v,
           loads[$urandom_range(0, 6)]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
